// File: rtl/mod8_down_counter.sv
// Free-running modulo-2**WIDTH down counter: presets to RESET_VALUE, then decrements and wraps 0 -> max.
// Latency: count updates on every rising clk edge; no combinational path from any input to count.
// Backpressure: none; there is no enable or stall, so the counter advances on every edge.
module mod8_down_counter #(
  parameter int unsigned          WIDTH       = 3,
  parameter logic [WIDTH-1:0]     RESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count
);

  // Synchronous preset has priority; otherwise decrement, letting unsigned underflow give the wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= RESET_VALUE;
    end else begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_mod8_down_counter.sv
module tb_mod8_down_counter;

  logic       clk;
  logic       reset;
  logic [2:0] count;

  int n_cmp;
  int n_bad;
  int exp_cnt;
  bit exp_known;

  mod8_down_counter dut (
    .clk   (clk),
    .reset (reset),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: count=%0d expected=%0d at t=%0t", tag, obs, expv, $time);
    end
  endtask

  // Reference: reset loads 7, otherwise value goes down by one modulo 8.
  function automatic int next_val(input int cur, input bit r);
    if (r) return 7;
    return ((cur - 1) % 8 + 8) % 8;
  endfunction

  // Apply one edge with the given reset level, update the model and compare.
  task automatic tick(input bit r, input string tag);
    reset = r;
    @(posedge clk);
    #1;
    if (r) begin
      exp_cnt   = 7;
      exp_known = 1'b1;
    end else if (exp_known) begin
      exp_cnt = next_val(exp_cnt, 1'b0);
    end
    if (exp_known) chk(tag, count, 3'(exp_cnt));
  endtask

  initial begin
    logic [2:0] seq [8];
    n_cmp     = 0;
    n_bad     = 0;
    exp_cnt   = 0;
    exp_known = 1'b0;
    reset     = 1'b0;
    seq = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};

    // Free-run before any reset: value is not defined, nothing to compare.
    tick(1'b0, "pre_reset");
    tick(1'b0, "pre_reset");

    // First reset edge, then reset held for three more edges.
    tick(1'b1, "first_reset");
    for (int i = 0; i < 3; i++) tick(1'b1, "reset_hold");

    // Full down sequence against a fixed table as well as the model.
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, "down_seq");
      chk("down_seq_table", count, seq[i]);
    end

    // Walk to 0, then wrap 0 -> 7 -> 6, then 16 more edges return to 6.
    for (int i = 0; i < 7; i++) tick(1'b0, "to_zero");
    chk("at_zero", count, 3'd0);
    tick(1'b0, "wrap_to_7");
    chk("wrap_7", count, 3'd7);
    tick(1'b0, "wrap_to_6");
    for (int i = 0; i < 16; i++) tick(1'b0, "period");
    chk("period_8", count, 3'd6);

    // Reset mid-count from 3.
    for (int i = 0; i < 8 && exp_cnt != 3; i++) tick(1'b0, "to_three");
    chk("at_three", count, 3'd3);
    tick(1'b1, "mid_reset");
    chk("mid_reset_7", count, 3'd7);
    tick(1'b0, "resume");
    chk("resume_6", count, 3'd6);

    // Reset pulse entirely between two edges must be ignored.
    tick(1'b0, "to_five");
    chk("at_five", count, 3'd5);
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    exp_cnt = next_val(exp_cnt, 1'b0);
    chk("pulse_ignored", count, 3'd4);

    // Randomized reset stream against the model.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 9) == 0), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mod8_down_counter.md
Name: mod8_down_counter

Overview:
- Free-running 3-bit modulo-8 down counter.
- Presets to 7 on reset, then decrements by one on every rising clock edge, wrapping 0 -> 7.
- Used as a simple sequence/phase generator or divide-by-8 timing source inside a single clock domain.
- Purely synchronous: no enable, no load, no direction control.

Parameters:
- WIDTH, 3, counter width in bits. Modulus is 2**WIDTH. Only 3 is required to be supported; the default must give mod-8 behaviour.
- RESET_VALUE, 7 (2**WIDTH-1), value loaded into count by reset.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- count  output  3 (WIDTH)  current counter value, driven directly from a register.

Behaviour:
- One clock; reset is synchronous and active-high.
  - Sampled only on the rising edge of clk.
  - A reset pulse that starts and ends between two rising edges has no effect.
- Reset:
  - On a rising edge with reset=1, count <= 7 (RESET_VALUE).
  - Reset has priority over counting.
  - Reset held high for N edges keeps count at 7 for all N edges.
- Count:
  - On a rising edge with reset=0, count <= count - 1, modulo 8.
  - Sequence: 7, 6, 5, 4, 3, 2, 1, 0, 7, 6, ...
- Wrap-around: from 0 the next value is 7. The wrap is natural unsigned 3-bit underflow; no extra flag, no stall.
- Latency:
  - count updates on the same edge that samples the inputs; the new value is visible immediately after that edge.
  - There is no combinational path from any input to count.
- Reset mid-sequence: count returns to 7 on that edge, regardless of its current value. Decrementing resumes on the first edge with reset=0 (7 -> 6).
- Power-up: count is undefined (X in simulation) until the first edge with reset=1. No initial blocks or async preset.
- No other state. The output is exactly the register value, with no glitches between edges.
- Width rule: arithmetic is unsigned, truncated to WIDTH bits.

Test Plan:
1. Synchronous reset: drive reset=1 across one rising edge -> count=7 after that edge. Hold reset=1 for 3 edges -> count stays 7.
2. Full down sequence: after reset, drive reset=0 and apply 8 edges -> count after each edge = 6, 5, 4, 3, 2, 1, 0, 7.
3. Wrap and continue: from count=0, apply 2 edges -> 7 then 6. Run 16 more edges -> count returns to 6, confirming period 8.
4. Reset mid-count: count=3, then reset=1 for one edge -> count=7. Release reset -> next edge gives 6.
5. Async-pulse rejection: count=5, then pulse reset high and back low entirely between two rising edges -> next edge gives 4, not 7.
6. Pre-reset state: clock before any reset -> count is X. The first edge with reset=1 yields 7.
